// File: rtl/mix_product_sched_if.sv
// mix_product_sched_if: request and result handshake bundle for mix_product_sched.
//   req_valid/req_ready/req_data : NREQ requesters, four DATA_W operands each
//   out_valid/out_ready          : result handshake
//   out_data/out_id              : XOR-reduced result and originating requester index
// Modports: master = requesters plus result consumer, slave = scheduler.
interface mix_product_sched_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREQ   = 4
);
    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SET_W = 4 * DATA_W;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SET_W-1:0] req_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic [ID_W-1:0]      out_id;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/mix_product_sched.sv
// mix_product_sched: shared scheduler for a four-operand XOR-reduce datapath.
// Arbitrates among NREQ requesters, pushes the winning operand set through a
// two-stage pipeline (A: operands, B: XOR result) and returns the result
// tagged with the requester index.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   run  : level enable for new grants; in-flight entries always drain
//   busy : either pipeline stage occupied
//   bus  : mix_product_sched_if.slave (requests in, tagged results out)
// Build option: MIX_PRODUCT_SCHED_RR_EN selects round-robin arbitration;
// otherwise fixed priority, lowest index wins.
module mix_product_sched #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREQ   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic                   busy,
    mix_product_sched_if.slave     bus
);
    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SET_W = 4 * DATA_W;

    logic [NREQ-1:0]   grant;
    logic              found;
    logic              can_a;
    logic              can_b;
    logic              grant_en;
    logic              accept;
    logic [ID_W-1:0]   acc_idx;
    logic [SET_W-1:0]  acc_data;

    logic              valid_a;
    logic [ID_W-1:0]   id_a;
    logic [SET_W-1:0]  a_data;
    logic [DATA_W-1:0] mix_a;

    logic              valid_b;
    logic [ID_W-1:0]   id_b;
    logic [DATA_W-1:0] b_data;

    // Pipeline advance conditions
    assign can_b    = !valid_b || bus.out_ready;
    assign can_a    = !valid_a || can_b;
    // Reset also masks ready so nothing is offered while the pipe is being cleared
    assign grant_en = can_a && run && rst;

`ifdef MIX_PRODUCT_SCHED_RR_EN
    logic [ID_W-1:0] ptr;

    // Round-robin pick: first valid index at or after ptr, then wrap to below ptr
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && bus.req_valid[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && bus.req_valid[i] && (i < int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Pointer moves to the slot after the accepted requester, only on accept
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (acc_idx == ID_W'(NREQ - 1)) ? '0 : acc_idx + ID_W'(1);
        end
    end
`else
    // Fixed priority pick: lowest valid index
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && bus.req_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    // Encode the one-hot grant and select the winner's operand set
    always_comb begin
        acc_idx  = '0;
        acc_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                acc_idx  = ID_W'(i);
                acc_data = bus.req_data[i*SET_W +: SET_W];
            end
        end
    end

    // grant only ever selects a valid requester, so any granted bit is an accept
    assign accept        = found && grant_en;
    assign bus.req_ready = grant & {NREQ{grant_en}};

    // Stage A: operand capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_a <= 1'b0;
            id_a    <= '0;
            a_data  <= '0;
        end else if (can_a) begin
            valid_a <= accept;
            if (accept) begin
                id_a   <= acc_idx;
                a_data <= acc_data;
            end
        end
    end

    assign mix_a = a_data[0*DATA_W +: DATA_W] ^ a_data[1*DATA_W +: DATA_W]
                 ^ a_data[2*DATA_W +: DATA_W] ^ a_data[3*DATA_W +: DATA_W];

    // Stage B: XOR result; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_b <= 1'b0;
            id_b    <= '0;
            b_data  <= '0;
        end else if (can_b) begin
            valid_b <= valid_a;
            if (valid_a) begin
                id_b   <= id_a;
                b_data <= mix_a;
            end
        end
    end

    assign bus.out_valid = valid_b;
    assign bus.out_data  = b_data;
    assign bus.out_id    = id_b;
    assign busy          = valid_a || valid_b;

endmodule

// File: tb/tb_mix_product_sched.sv
// tb_mix_product_sched: directed bench for mix_product_sched (DATA_W=32, NREQ=4).
// A cycle table covers single requests, the all-ones XOR case and backpressure;
// hand sequences cover the burst order, run drop/resume and mid-stream reset.
module tb_mix_product_sched;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREQ   = 4;
`ifdef MIX_PRODUCT_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    logic run;
    logic busy;

    mix_product_sched_if #(.DATA_W(DATA_W), .NREQ(NREQ)) bus ();

    mix_product_sched #(.DATA_W(DATA_W), .NREQ(NREQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .busy (busy),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  rv;
        logic        ordy;
        logic [31:0] op2;
        logic [3:0]  rr;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  oid;
        logic        busy;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] ops[4][4];
    logic [31:0] exp_od[4];
    int          n_chk;
    int          n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rn, input logic [3:0] rv, input logic ordy,
                       input logic [31:0] op2, input logic [3:0] rr, input logic ov,
                       input logic [31:0] od, input logic [1:0] oid, input logic bsy);
        vec_t v;
        v.rst = r; v.run = rn; v.rv = rv; v.ordy = ordy; v.op2 = op2;
        v.rr = rr; v.ov = ov; v.od = od; v.oid = oid; v.busy = bsy;
        vq.push_back(v);
    endtask

    task automatic drive_data();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                bus.req_data[(i*4+k)*32 +: 32] = ops[i][k];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        int first;
        int last;
        int eid;

        n_chk  = 0;
        n_fail = 0;
        ops[0] = '{32'h1, 32'h2, 32'h4, 32'h8};
        ops[1] = '{32'h11111111, 32'h22222222, 32'h44444444, 32'h0};
        ops[2] = '{32'h100, 32'h0, 32'h0, 32'h0};
        ops[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h0};
        exp_od[0] = 32'hF;
        exp_od[1] = 32'h77777777;
        exp_od[2] = 32'h40;
        exp_od[3] = 32'hA5A5A5A5;

        rst = 1'b0;
        run = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        drive_data();
        repeat (2) @(negedge clk);

        //   rst run rv     ordy op2      rr     ov od            id busy
        add(0, 1, 4'b0001, 1, 32'h100, 4'b0000, 0, 32'h0,        0, 0);
        add(1, 1, 4'b0001, 1, 32'h100, 4'b0001, 0, 32'h0,        0, 0);
        add(1, 1, 4'b0000, 1, 32'h100, 4'b0000, 0, 32'h0,        0, 1);
        add(1, 1, 4'b0000, 1, 32'h100, 4'b0000, 1, 32'hF,        0, 1);
        add(1, 1, 4'b1000, 1, 32'h100, 4'b1000, 0, 32'h0,        0, 0);
        add(1, 1, 4'b0000, 1, 32'h100, 4'b0000, 0, 32'h0,        0, 1);
        add(1, 1, 4'b0000, 1, 32'h100, 4'b0000, 1, 32'hA5A5A5A5, 3, 1);
        add(1, 1, 4'b0000, 1, 32'h100, 4'b0000, 0, 32'h0,        0, 0);
        add(1, 1, 4'b0100, 0, 32'h100, 4'b0100, 0, 32'h0,        0, 0);
        add(1, 1, 4'b0100, 0, 32'h200, 4'b0100, 0, 32'h0,        0, 1);
        add(1, 1, 4'b0100, 0, 32'h300, 4'b0000, 1, 32'h100,      2, 1);
        add(1, 1, 4'b0100, 0, 32'h300, 4'b0000, 1, 32'h100,      2, 1);
        add(1, 1, 4'b0100, 0, 32'h300, 4'b0000, 1, 32'h100,      2, 1);
        add(1, 1, 4'b0100, 1, 32'h300, 4'b0100, 1, 32'h100,      2, 1);
        add(1, 1, 4'b0000, 1, 32'h300, 4'b0000, 1, 32'h200,      2, 1);
        add(1, 1, 4'b0000, 1, 32'h300, 4'b0000, 1, 32'h300,      2, 1);
        add(1, 1, 4'b0000, 1, 32'h300, 4'b0000, 0, 32'h0,        0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst           = vq[i].rst;
            run           = vq[i].run;
            bus.req_valid = vq[i].rv;
            bus.out_ready = vq[i].ordy;
            ops[2][0]     = vq[i].op2;
            drive_data();
            #1;
            chk($sformatf("v%0d_req_ready", i), 64'(bus.req_ready), 64'(vq[i].rr));
            chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vq[i].ov));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vq[i].busy));
            if (vq[i].ov) begin
                chk($sformatf("v%0d_out_data", i), 64'(bus.out_data), 64'(vq[i].od));
                chk($sformatf("v%0d_out_id", i), 64'(bus.out_id), 64'(vq[i].oid));
            end
            @(negedge clk);
        end

        // Burst: all requesters valid for 8 cycles after a fresh reset
        rst = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        run = 1'b1;
        bus.out_ready = 1'b1;
        ops[2][0] = 32'h40;
        drive_data();
        bus.req_valid = 4'hF;
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 20 && got < 8; c++) begin
            if (c == 8) bus.req_valid = '0;
            #1;
            if (bus.out_valid) begin
                eid = RR ? (got % 4) : 0;
                chk($sformatf("burst%0d_id", got), 64'(bus.out_id), 64'(eid));
                chk($sformatf("burst%0d_data", got), 64'(bus.out_data), 64'(exp_od[eid]));
                if (got == 0) first = c;
                last = c;
                got++;
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        chk("burst_count", 64'(got), 64'(8));
        chk("burst_back_to_back", 64'(last - first), 64'(7));
        repeat (3) @(negedge clk);
        #1;
        chk("burst_idle_busy", 64'(busy), 64'(0));

        // Run drop with two entries in flight, then resume
        run = 1'b1;
        bus.req_valid = 4'hF;
        #1;
        chk("run_grant0", 64'(bus.req_ready), 64'(4'b0001));
        @(negedge clk);
        #1;
        chk("run_grant1", 64'(bus.req_ready), 64'(RR ? 4'b0010 : 4'b0001));
        @(negedge clk);
        run = 1'b0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("stop%0d_ready", c), 64'(bus.req_ready), 64'(0));
            if (bus.out_valid) begin
                eid = RR ? got : 0;
                chk($sformatf("stop_res%0d_id", got), 64'(bus.out_id), 64'(eid));
                chk($sformatf("stop_res%0d_data", got), 64'(bus.out_data), 64'(exp_od[eid & 3]));
                got++;
            end
            if (got == 2 && !busy) break;
            @(negedge clk);
        end
        chk("stop_drained", 64'(got), 64'(2));
        chk("stop_busy", 64'(busy), 64'(0));
        run = 1'b1;
        #1;
        chk("resume_grant", 64'(bus.req_ready), 64'(RR ? 4'b0100 : 4'b0001));
        bus.req_valid = '0;
        @(negedge clk);

        // Reset with both stages full
        ops[2][0] = 32'h55;
        drive_data();
        bus.req_valid = 4'b0100;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("full_ready", 64'(bus.req_ready), 64'(0));
        chk("full_valid", 64'(bus.out_valid), 64'(1));
        chk("full_data", 64'(bus.out_data), 64'(32'h55));
        chk("full_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_id", 64'(bus.out_id), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_first_grant", 64'(bus.req_ready), 64'(4'b0001));
        bus.req_valid = '0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
